ind_bus_master: RTL
===================

IND_BUS_MASTER -- requirements
Module: ind_bus_master

Interface
REQ-001 Parameter STROBE_CYCLES, default 2, SHALL set the number of cycles cs stays high per transaction (legal 1..15).
REQ-002 Parameter FIFO_DEPTH, default 4, SHALL set the command FIFO depth (power of two, legal 2..16).
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 cmd_valid  in  1  command offered.
REQ-006 cmd_ready  out  1  command FIFO not full.
REQ-007 cmd_wr  in  1  1 = write, 0 = read.
REQ-008 cmd_addr  in  4  peripheral register address.
REQ-009 cmd_wdata  in  8  write data, ignored for reads.
REQ-010 addr  out  4  bus address to peripherals.
REQ-011 cs  out  1  bus chip select.
REQ-012 wr  out  1  bus write strobe.
REQ-013 rd  out  1  bus read strobe.
REQ-014 wdata  out  8  bus write data.
REQ-015 rdata_in  in  8  bus read data from the selected peripheral.
REQ-016 rsp_valid  out  1  one-cycle pulse: read data available.
REQ-017 rsp_data  out  8  captured read data, held until the next read completes.
REQ-018 busy  out  1  FIFO non-empty or FSM not IDLE.

Function
REQ-019 A command SHALL be pushed when cmd_valid and cmd_ready are both 1 at a rising edge; cmd_ready SHALL be 0 exactly when the FIFO holds FIFO_DEPTH entries.
REQ-020 A push and a pop in the same cycle SHALL leave the count unchanged; a push while full SHALL NOT happen (cmd_ready is 0), and a pop while empty SHALL NOT happen.
REQ-021 The FSM SHALL have states IDLE, SETUP, STROBE and HOLD.
REQ-022 IDLE->SETUP when the FIFO is non-empty, popping the head and registering addr, wdata and the direction; cs, rd and wr = 0 in SETUP.
REQ-023 SETUP->STROBE after 1 cycle; in STROBE cs = 1 and wr = direction, rd = ~direction, for exactly STROBE_CYCLES cycles, counted by a 4-bit down-counter.
REQ-024 STROBE->HOLD: cs, rd and wr = 0, addr and wdata held for 1 cycle; HOLD->SETUP (with pop) if the FIFO is non-empty, else HOLD->IDLE.
REQ-025 Latency: a push at edge N into an empty FIFO with the FSM in IDLE SHALL give SETUP from N+1, cs = 1 from N+2 to N+2+STROBE_CYCLES, and HOLD for one cycle after that; back-to-back transactions SHALL take 2+STROBE_CYCLES cycles each.
REQ-026 For reads, rdata_in SHALL be sampled at the rising edge that ends the last STROBE cycle; rsp_data SHALL update at that edge and rsp_valid SHALL be 1 during the HOLD cycle only; writes SHALL NOT pulse rsp_valid.
REQ-027 All bus outputs SHALL be registered and change only on rising edges, so they are stable at the falling edge, where peripherals sample.
REQ-028 cs, rd and wr SHALL never be 1 outside STROBE, and rd and wr SHALL never be 1 together.
REQ-029 FIFO pointers SHALL wrap modulo FIFO_DEPTH; the count SHALL be log2(FIFO_DEPTH)+1 bits wide.

Reset
REQ-030 When rst = 0, the block SHALL asynchronously enter IDLE, empty the FIFO and drive addr = 0, wdata = 0, cs = rd = wr = 0, rsp_valid = 0, rsp_data = 0 and busy = 0; cmd_ready = 1 after reset.
REQ-031 Reset asserted mid-transaction SHALL drop the strobes immediately, discard the transaction and the queued commands, and emit no rsp_valid.

Structure
REQ-032 A shared package SHALL hold the FSM state encoding, the 13-bit command field layout {wr, addr[3:0], wdata[7:0]} and the bus width constants.
REQ-033 The command FIFO SHALL be a separate sub-module, cmd_fifo (parameters width and depth, with full, empty and count outputs); the FSM SHALL live in ind_bus_master.

Verification
REQ-034 Single write: addr 0x2, wdata 0xA5, STROBE_CYCLES = 2 -> cs = wr = 1 for 2 cycles starting 2 cycles after the push, addr = 0x2, rd = 0, no rsp_valid.
REQ-035 Single read: addr 0x4, rdata_in = 0x3C -> rd = cs = 1 for 2 cycles, then rsp_valid pulses once with rsp_data = 0x3C.
REQ-036 Burst: push 5 commands back-to-back with FIFO_DEPTH = 4 -> cmd_ready = 0 after 4 buffered, the 5th is accepted after the first pop, and all 5 run in order 4 cycles apart with no IDLE between them.
REQ-037 Reset mid-STROBE with 2 commands queued -> cs, rd and wr = 0 in the same cycle, busy = 0, and no further bus activity after rst returns to 1.
REQ-038 STROBE_CYCLES = 1 and 15 -> cs width is exactly 1 and 15 cycles; a checker confirms rd and wr are never 1 together and never 1 outside cs.

Source files
------------

// File: rtl/ind_bus_master_pkg.sv
// ind_bus_master_pkg: shared FSM encoding, command layout and bus widths
package ind_bus_master_pkg;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int CMD_W  = 1 + ADDR_W + DATA_W;
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;
  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;
endpackage

// File: rtl/ind_bus_master_cmd_fifo.sv
// cmd_fifo: power-of-two command queue with full/empty flags and occupancy count
module cmd_fifo #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp, rp;
  assign dout  = mem[rp];
  assign full  = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  // pointers wrap naturally because the depth is a power of two
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end
  // storage needs no reset: only entries below count are ever read
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= din;
  end
endmodule

// File: rtl/ind_bus_master.sv
// ind_bus_master: queues commands and plays them out as SETUP/STROBE/HOLD bus cycles
module ind_bus_master
  import ind_bus_master_pkg::*;
#(
  parameter int STROBE_CYCLES = 2,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_wr,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic [ADDR_W-1:0] addr,
  output logic              cs,
  output logic              wr,
  output logic              rd,
  output logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata_in,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  state_t          state, next;
  logic [3:0]      cnt;
  logic            dir, pop, full, empty, last;
  logic [CW-1:0]   count;
  cmd_t            head;
  cmd_fifo #(.WIDTH(CMD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_valid && !full),
    .din   ({cmd_wr, cmd_addr, cmd_wdata}),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );
  assign cmd_ready = !full;
  assign busy      = count != '0 || state != IDLE;
  assign last      = state == STROBE && cnt == 4'd0;
  // next state; a new command is popped whenever the bus is free (IDLE or HOLD)
  always_comb begin
    pop  = (state == IDLE || state == HOLD) && !empty;
    next = pop ? SETUP : state == SETUP ? STROBE : state == STROBE ? (last ? HOLD : STROBE) : IDLE;
  end
  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else state <= next;
  end
  // registered bus outputs, strobe counter and read-data capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      dir       <= 1'b0;
      addr      <= '0;
      wdata     <= '0;
      cs        <= 1'b0;
      wr        <= 1'b0;
      rd        <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      cnt <= state == SETUP ? 4'(STROBE_CYCLES - 1) : state == STROBE ? cnt - 4'd1 : cnt;
      if (pop) begin
        dir   <= head.wr;
        addr  <= head.addr;
        wdata <= head.wdata;
      end
      cs        <= next == STROBE;
      wr        <= next == STROBE && dir;
      rd        <= next == STROBE && !dir;
      rsp_valid <= last && !dir;
      if (last && !dir) rsp_data <= rdata_in;
    end
  end
endmodule
